cond_sink_sched: RTL and testbench

- Clocked scheduler that drives the control channel (rctl/dctl/actl, 4-phase) of a conditional sink.
- Issues a repeating pass/drop pattern: pass KEEP data tokens, then drop DROP tokens, then repeat.
- Used for decimation and throttling of bundled-data streams.
- Sits next to the two-way conditional sink; actl from the async sink is synchronised internally.

---
 rtl/cond_sink_sched_if.sv | 10 +
 rtl/cond_sink_sched.sv | 133 +++++++++++++
 tb/tb_cond_sink_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cond_sink_sched_if.sv
// Control channel of a two-way conditional sink: 4-phase rctl/actl handshake
// with dctl (1=pass, 0=drop) bundled against rctl.
interface cond_sink_sched_if;
  logic rctl;
  logic dctl;
  logic actl;

  modport master (output rctl, output dctl, input actl);
  modport slave  (input rctl, input dctl, output actl);
endinterface

// File: rtl/cond_sink_sched.sv
// Pass/drop pattern scheduler for a conditional sink control channel.
// Issues KEEP pass tokens then DROP drop tokens, repeating, over a 4-phase
// bundled-data channel. The acknowledge is asynchronous and is synchronised
// internally before any decision uses it.
// Optional build macro: COND_SINK_SCHED_STATS_EN adds saturating 16-bit
// pass/drop token counters; without it both count ports read as zero.
module cond_sink_sched #(
  parameter int unsigned CW   = 8,
  parameter int unsigned SYNC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [CW-1:0]         keep_i,
  input  logic [CW-1:0]         drop_i,
  cond_sink_sched_if.master     ctl,
  output logic                  busy_o,
  output logic [15:0]           pass_cnt_o,
  output logic [15:0]           drop_cnt_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StReq, StRtz} state_e;

  state_e          state_q, state_d;
  logic [SYNC-1:0] sync_q;
  logic            actl_s;
  logic [CW:0]     pos_q, pos_d;
  logic [CW-1:0]   kq_q, kq_d, dq_q, dq_d;
  logic            rctl_q, rctl_d;
  logic            dctl_q, dctl_d;

  logic            pos_zero;
  logic [CW:0]     sum_in, sum_q, pos_inc;
  logic [CW-1:0]   kq_eff;
  logic            pat_nz;
  logic            tok_done;

  assign actl_s   = sync_q[SYNC-1];
  assign pos_zero = (pos_q == '0);
  assign sum_in   = {1'b0, keep_i} + {1'b0, drop_i};
  assign sum_q    = {1'b0, kq_q} + {1'b0, dq_q};
  assign pos_inc  = pos_q + {{CW{1'b0}}, 1'b1};
  // At a period boundary the fresh inputs are about to be latched, so they decide.
  assign kq_eff   = pos_zero ? keep_i : kq_q;
  assign pat_nz   = pos_zero ? (sum_in != '0) : (sum_q != '0);
  assign tok_done = (state_q == StRtz) && !actl_s;

  // Acknowledge synchroniser.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC-2:0], ctl.actl};
  end

  // State, pattern and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pos_q   <= '0;
      kq_q    <= '0;
      dq_q    <= '0;
      rctl_q  <= 1'b0;
      dctl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      kq_q    <= kq_d;
      dq_q    <= dq_d;
      rctl_q  <= rctl_d;
      dctl_q  <= dctl_d;
    end
  end

  // Next-state logic; dctl is set on entry to SETUP so it is stable a full
  // cycle before rctl rises and is held until the next token.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    kq_d    = kq_q;
    dq_d    = dq_q;
    dctl_d  = dctl_q;
    unique case (state_q)
      StIdle: begin
        if (en_i && pat_nz) begin
          state_d = StSetup;
          if (pos_zero) begin
            kq_d = keep_i;
            dq_d = drop_i;
          end
          dctl_d = (pos_q < {1'b0, kq_eff});
        end
      end
      StSetup: state_d = StReq;
      StReq: begin
        if (actl_s) state_d = StRtz;
      end
      StRtz: begin
        if (!actl_s) begin
          state_d = StIdle;
          pos_d   = (pos_inc == sum_q) ? '0 : pos_inc;
        end
      end
    endcase
    rctl_d = (state_d == StReq);
  end

  assign ctl.rctl = rctl_q;
  assign ctl.dctl = dctl_q;
  assign busy_o   = (state_q != StIdle);

`ifdef COND_SINK_SCHED_STATS_EN
  logic [15:0] pass_q, drop_q;

  // Saturating token counters, bumped as each handshake retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= '0;
      drop_q <= '0;
    end else if (tok_done) begin
      if (dctl_q && pass_q != 16'hFFFF)  pass_q <= pass_q + 16'd1;
      if (!dctl_q && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign pass_cnt_o = pass_q;
  assign drop_cnt_o = drop_q;
`else
  logic unused_tok_done;
  assign unused_tok_done = tok_done;
  assign pass_cnt_o      = '0;
  assign drop_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_cond_sink_sched.sv
// Scoreboard bench for cond_sink_sched: stimulus pushes expected dctl values,
// a monitor pops one per rising rctl and checks dctl stays put while rctl is high.
module tb_cond_sink_sched;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_i = 1'b0;
  logic [CW-1:0] keep_i = '0;
  logic [CW-1:0] drop_i = '0;
  logic          busy_o;
  logic [15:0]   pass_cnt_o, drop_cnt_o;

  cond_sink_sched_if bus ();

  cond_sink_sched #(.CW(CW), .SYNC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .keep_i     (keep_i),
    .drop_i     (drop_i),
    .ctl        (bus),
    .busy_o     (busy_o),
    .pass_cnt_o (pass_cnt_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tok_seen = 0;
  bit exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Sink-side responder: actl follows rctl three cycles later; reset with the block.
  initial begin
    logic [2:0] dly = '0;
    bus.actl = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        dly = '0;
        bus.actl = 1'b0;
      end else begin
        bus.actl = dly[2];
        dly = {dly[1:0], bus.rctl};
      end
    end
  end

  // Monitor: one expected dctl per token, plus dctl stability across rctl high.
  initial begin
    bit prev_r = 0;
    bit in_tok = 0;
    bit rise_d = 0;
    bit moved = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_r = 0;
        in_tok = 0;
      end else begin
        if (bus.rctl && !prev_r) begin
          tok_seen++;
          rise_d = bus.dctl;
          moved  = 0;
          in_tok = 1;
          if (exp_q.size() == 0) check("unexpected_token", 1, 0);
          else check("dctl_token", int'(rise_d), int'(exp_q.pop_front()));
        end else if (bus.rctl && in_tok && bus.dctl != rise_d) begin
          moved = 1;
        end
        if (!bus.rctl && prev_r && in_tok) begin
          check("dctl_stable", int'(moved || bus.dctl != rise_d), 0);
          in_tok = 0;
        end
        prev_r = bus.rctl;
      end
    end
  end

  task automatic push(input bit v);
    exp_q.push_back(v);
  endtask

  task automatic wait_tokens(input int target);
    int n = 0;
    while (tok_seen < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("token_count", tok_seen, target);
  endtask

  task automatic go_idle();
    int n = 0;
    en_i = 1'b0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_drop", int'(busy_o), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int cnt_r, cnt_d, cnt_b;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cnt_r = 0; cnt_d = 0; cnt_b = 0;
    repeat (20) begin
      @(negedge clk);
      cnt_r += int'(bus.rctl);
      cnt_d += int'(bus.dctl);
      cnt_b += int'(busy_o);
    end
    check("idle_rctl", cnt_r, 0);
    check("idle_dctl", cnt_d, 0);
    check("idle_busy", cnt_b, 0);
    check("rst_pass_cnt", int'(pass_cnt_o), 0);
    check("rst_drop_cnt", int'(drop_cnt_o), 0);

    // keep=2 drop=1, nine tokens.
    keep_i = 8'd2; drop_i = 8'd1;
    for (int i = 0; i < 9; i++) push((i % 3) != 2);
    base = tok_seen;
    en_i = 1'b1;
    wait_tokens(base + 9);
    go_idle();
`ifdef COND_SINK_SCHED_STATS_EN
    check("pass_cnt_2_1", int'(pass_cnt_o), 6);
    check("drop_cnt_2_1", int'(drop_cnt_o), 3);
`else
    check("pass_cnt_off", int'(pass_cnt_o), 0);
    check("drop_cnt_off", int'(drop_cnt_o), 0);
`endif

    // Zero pattern: nothing issued.
    keep_i = 8'd0; drop_i = 8'd0;
    base = tok_seen;
    cnt_b = 0;
    en_i = 1'b1;
    repeat (50) begin
      @(negedge clk);
      cnt_b += int'(busy_o);
    end
    check("zero_pat_tokens", tok_seen - base, 0);
    check("zero_pat_busy", cnt_b, 0);
    en_i = 1'b0;

    // keep 1->3 mid-period with drop=2.
    keep_i = 8'd1; drop_i = 8'd2;
    push(1); push(0); push(0);
    push(1); push(1); push(1); push(0); push(0);
    base = tok_seen;
    en_i = 1'b1;
    wait_tokens(base + 1);
    keep_i = 8'd3;
    wait_tokens(base + 8);
    go_idle();

    // Drop enable mid-handshake at pos 1 of keep=3/drop=2; resume at pos 2.
    push(1); push(1);
    base = tok_seen;
    en_i = 1'b1;
    wait_tokens(base + 2);
    check("rctl_high_at_halt", int'(bus.rctl), 1);
    go_idle();
    repeat (20) @(negedge clk);
    check("halt_no_tokens", tok_seen - base, 2);
    push(1); push(0); push(0);
    en_i = 1'b1;
    wait_tokens(base + 5);
    go_idle();

    // Reset while in REQ with actl high.
    keep_i = 8'd2; drop_i = 8'd1;
    push(1);
    base = tok_seen;
    en_i = 1'b1;
    wait_tokens(base + 1);
    begin
      int n = 0;
      while (!bus.actl && n < 50) begin
        @(posedge clk);
        #3;
        n++;
      end
    end
    check("actl_high_in_req", int'(bus.actl), 1);
    check("rctl_before_rst", int'(bus.rctl), 1);
    rst = 1'b1;
    en_i = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rctl", int'(bus.rctl), 0);
    check("rst_dctl", int'(bus.dctl), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_pass_cnt2", int'(pass_cnt_o), 0);
    check("rst_drop_cnt2", int'(drop_cnt_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("queue_after_rst", exp_q.size(), 0);

    // pos cleared: a keep=1/drop=1 pattern starts with a pass.
    keep_i = 8'd1; drop_i = 8'd1;
    push(1); push(0);
    base = tok_seen;
    en_i = 1'b1;
    wait_tokens(base + 2);
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end
endmodule
